seven_seg_pair_decoder: RTL



---
 rtl/seven_seg_pair_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_pair_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pair_decoder
// Description : Recovers a 5-bit count {big bit, little nibble} from a pair of
//               active-low seven-segment digit patterns. The inputs are
//               sampled every cycle. A pattern pair is accepted only after it
//               has been held for STABLE_CYCLES consecutive samples. Illegal
//               pairs are flagged and counted, and the both-blank pair is
//               reported separately.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-high reset
//               lil_seg[6:0] - little digit segments g..a, active-low
//               big_seg[6:0] - big digit segments g..a, active-low
//               value[4:0]   - decoded count {big bit, little nibble}
//               valid        - high while value holds an accepted legal pair
//               new_value    - one-cycle pulse on acceptance of a legal pair
//               bad_pattern  - one-cycle pulse on acceptance of an illegal pair
//               blank        - high while the accepted pair is both-blank
//               err_count    - saturating count of bad_pattern pulses
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_pair_decoder #(
    parameter int STABLE_CYCLES = 4   // legal range 1-15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] lil_seg,
    input  logic [6:0] big_seg,
    output logic [4:0] value,
    output logic       valid,
    output logic       new_value,
    output logic       bad_pattern,
    output logic       blank,
    output logic [7:0] err_count
);

    localparam logic [1:0]  S_EMPTY  = 2'd0;
    localparam logic [1:0]  S_LOCKED = 2'd1;
    localparam logic [1:0]  S_FAULT  = 2'd2;
    localparam logic [1:0]  S_OFF    = 2'd3;

    localparam logic [3:0]  c_stable     = 4'(STABLE_CYCLES);
    localparam logic [13:0] c_blank_pair = 14'h3FFF;
    localparam logic [6:0]  c_seg_zero   = 7'b1000000;
    localparam logic [6:0]  c_seg_one    = 7'b1111001;
    localparam logic [7:0]  c_err_max    = 8'hFF;

    // Returns {legal, nibble} for one little-digit pattern.
    function automatic logic [4:0] lil_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: lil_decode = {1'b1, 4'h0};
            7'b1111001: lil_decode = {1'b1, 4'h1};
            7'b0100100: lil_decode = {1'b1, 4'h2};
            7'b0110000: lil_decode = {1'b1, 4'h3};
            7'b0011001: lil_decode = {1'b1, 4'h4};
            7'b0010010: lil_decode = {1'b1, 4'h5};
            7'b0000010: lil_decode = {1'b1, 4'h6};
            7'b1111000: lil_decode = {1'b1, 4'h7};
            7'b0000000: lil_decode = {1'b1, 4'h8};
            7'b0010000: lil_decode = {1'b1, 4'h9};
            7'b0001000: lil_decode = {1'b1, 4'hA};
            7'b0000011: lil_decode = {1'b1, 4'hB};
            7'b1000110: lil_decode = {1'b1, 4'hC};
            7'b0100001: lil_decode = {1'b1, 4'hD};
            7'b0000110: lil_decode = {1'b1, 4'hE};
            7'b0001110: lil_decode = {1'b1, 4'hF};
            default:    lil_decode = 5'b0_0000;
        endcase
    endfunction

    logic [13:0] r_sample;
    logic [13:0] r_accepted;
    logic [3:0]  r_cnt;
    logic        r_hit;
    logic [1:0]  r_state;

    logic [13:0] w_in_pair;
    logic        w_changed;
    logic [3:0]  w_cnt_next;
    logic [4:0]  w_lil;
    logic        w_big_legal;
    logic        w_big_bit;
    logic        w_is_blank;
    logic        w_legal;
    logic        w_fire;

    // ------------------------------------------------------------------
    // Stability tracking. The counter tracks how many consecutive samples
    // have been identical. r_hit marks the single cycle in which the
    // counter has just arrived at STABLE_CYCLES, so a pair held for a long
    // time produces exactly one acceptance attempt.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_pair  = {big_seg, lil_seg};
        w_changed  = (w_in_pair != r_sample);
        w_cnt_next = 4'd1;
        if (!w_changed) begin
            w_cnt_next = (r_cnt == c_stable) ? c_stable : r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= c_blank_pair;
            r_cnt    <= 4'd0;
            r_hit    <= 1'b0;
        end else begin
            r_sample <= w_in_pair;
            r_cnt    <= w_cnt_next;
            r_hit    <= (w_cnt_next == c_stable) && (w_changed || (r_cnt != c_stable));
        end
    end

    // ------------------------------------------------------------------
    // Classification of the stable sample. The both-blank pair is checked
    // ahead of legality, since each of its digits is illegal on its own.
    // ------------------------------------------------------------------
    always_comb begin
        w_lil       = lil_decode(r_sample[6:0]);
        w_big_legal = (r_sample[13:7] == c_seg_zero) || (r_sample[13:7] == c_seg_one);
        w_big_bit   = (r_sample[13:7] == c_seg_one);
        w_is_blank  = (r_sample == c_blank_pair);
        w_legal     = w_big_legal && w_lil[4];
        // A re-presented pair is ignored unless nothing has been accepted yet.
        w_fire      = r_hit && ((r_sample != r_accepted) || (r_state == S_EMPTY));
    end

    // ------------------------------------------------------------------
    // Acceptance FSM and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_accepted  <= c_blank_pair;
            value       <= 5'd0;
            valid       <= 1'b0;
            new_value   <= 1'b0;
            bad_pattern <= 1'b0;
            blank       <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            new_value   <= 1'b0;
            bad_pattern <= 1'b0;
            if (w_fire) begin
                r_accepted <= r_sample;
                if (w_is_blank) begin
                    r_state <= S_OFF;
                    valid   <= 1'b0;
                    blank   <= 1'b1;
                end else if (w_legal) begin
                    r_state   <= S_LOCKED;
                    value     <= {w_big_bit, w_lil[3:0]};
                    valid     <= 1'b1;
                    new_value <= 1'b1;
                    blank     <= 1'b0;
                end else begin
                    // value deliberately keeps the last legal reading
                    r_state     <= S_FAULT;
                    valid       <= 1'b0;
                    bad_pattern <= 1'b1;
                    blank       <= 1'b0;
                    if (err_count != c_err_max) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
